// File: rtl/dmem_lsu.sv
// RV32I MEM-stage load/store unit with word-organised byte-enabled data RAM.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses are dropped and flagged.
module dmem_lsu #(
   parameter  int DEPTH_WORDS = 1024,
   localparam int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_en_dmem,
   input  logic        i_load_store,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_rvalid,
   output logic        o_stall,
   output logic        o_misalign
);

   typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

   state_t         state_q, state_d;
   logic [31:0]    mem [DEPTH_WORDS];
   logic [AW-1:0]  idx, idx_q;
   logic [1:0]     lane, lane_q;
   logic [2:0]     f3_q;
   logic           cmd, ld_acc, st_acc;
   logic [3:0]     be;
   logic [31:0]    wd;
   logic           unused_addr;

   assign idx         = i_addr[AW+1:2];
   assign lane        = i_addr[1:0];
   assign unused_addr = ^i_addr[31:AW+2];

   assign cmd     = i_rst_n & i_en_dmem & (state_q == IDLE);
   assign ld_acc  = cmd & ~i_load_store;
   assign st_acc  = cmd & i_load_store;
   assign o_stall = ld_acc | (state_q == READ);

   function automatic logic [31:0] extract(input logic [31:0] w,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  ln);
      logic [31:0] s;
      logic [7:0]  b;
      logic [15:0] h;
      s = w >> {ln, 3'b000};
      b = s[7:0];
      h = ln[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  extract = {{24{b[7]}}, b};
         3'b001:  extract = {{16{h[15]}}, h};
         3'b010:  extract = w;
         3'b100:  extract = {24'h0, b};
         3'b101:  extract = {16'h0, h};
         default: extract = 32'h0;
      endcase
   endfunction

`ifdef MISALIGN_TRAP_EN
   logic mis, mis_q, mis_rsp_q;
   assign mis = ((i_funct3 == 3'b001 || i_funct3 == 3'b101) && lane[0]) ||
                ((i_funct3 == 3'b010) && (lane != 2'b00));
   assign o_misalign = (st_acc & mis & ~i_funct3[2]) | mis_rsp_q;
`else
   assign o_misalign = 1'b0;
`endif

   // Narrow stores replicate their data so any enabled lane sees it.
   always_comb begin
      be = '0;
      wd = i_wdata;
      case (i_funct3)
         3'b000: begin
            be = 4'b0001 << lane;
            wd = {4{i_wdata[7:0]}};
         end
         3'b001: begin
            be = 4'b0011 << {lane[1], 1'b0};
            wd = {2{i_wdata[15:0]}};
         end
         3'b010:  be = 4'b1111;
         default: be = '0;
      endcase
`ifdef MISALIGN_TRAP_EN
      if (mis) be = '0;
`endif
   end

   always_ff @(posedge i_clk) begin
      if (st_acc) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ld_acc) state_d = READ;
         READ:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         lane_q    <= '0;
         f3_q      <= '0;
         o_rdata   <= '0;
         o_rvalid  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         mis_q     <= 1'b0;
         mis_rsp_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         o_rvalid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         mis_rsp_q <= 1'b0;
`endif
         if (ld_acc) begin
            idx_q  <= idx;
            lane_q <= lane;
            f3_q   <= i_funct3;
`ifdef MISALIGN_TRAP_EN
            mis_q  <= mis;
`endif
         end
         // Registered RAM read; the result is presented during RESP.
         if (state_q == READ) begin
            o_rvalid <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            mis_rsp_q <= mis_q;
            o_rdata   <= mis_q ? 32'h0 : extract(mem[idx_q], f3_q, lane_q);
`else
            o_rdata   <= extract(mem[idx_q], f3_q, lane_q);
`endif
         end
      end
   end

endmodule
